// File: rtl/countdown_timer.sv
// Programmable down-counter: loads over a valid/ready handshake, decrements
// once per PRESCALE clocks, pulses 'expired' at terminal count, sets sticky irq.
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             mode_periodic,
  input  logic             irq_clear,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             expired,
  output logic             irq
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  count_next;
  logic [WIDTH-1:0]  reload, reload_next;
  logic [PW-1:0]     presc, presc_next;
  logic              mode, mode_next;
  logic              expired_next;
  logic              irq_next;

  logic              open_state;
  logic [WIDTH-1:0]  start_src;
  logic              tick;
  logic              at_one;

  assign open_state = (state == IDLE) || (state == DONE);
  assign load_ready = open_state;
  assign busy       = (state == RUN) || (state == PAUSED);

  // A restart from DONE re-arms from the stored reload value, since the
  // visible count has already run down to zero.
  assign start_src  = (state == DONE) ? reload : count_out;
  assign tick       = (state == RUN) && (presc == PRESC_LAST);
  assign at_one     = (count_out == WIDTH'(1));

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the decision chain below can leave one unassigned (no latches).
  always_comb begin
    state_next   = state;
    count_next   = count_out;
    reload_next  = reload;
    presc_next   = presc;
    mode_next    = mode;
    expired_next = 1'b0;
    // The cycle in which expired is high also counts as a set, so a clear
    // arriving alongside the pulse cannot win.
    irq_next     = expired | (irq & ~irq_clear);

    if (stop) begin
      state_next = IDLE;
      presc_next = '0;
    end else if (load_valid && open_state) begin
      reload_next = load_value;
      count_next  = load_value;
      state_next  = IDLE;
    end else if (start && open_state) begin
      if (start_src != '0) begin
        count_next = start_src;
        state_next = RUN;
        presc_next = '0;
        mode_next  = mode_periodic;
      end
    end else if (start && (state == PAUSED)) begin
      state_next = RUN;
    end else if (pause && (state == RUN)) begin
      state_next = PAUSED;
    end else if (state == RUN) begin
      if (tick) begin
        presc_next = '0;
        if (at_one) begin
          expired_next = 1'b1;
          irq_next     = 1'b1;
          if (mode) begin
            count_next = reload;
          end else begin
            count_next = '0;
            state_next = DONE;
          end
        end else if (count_out != '0) begin
          count_next = count_out - WIDTH'(1);
        end
      end else begin
        presc_next = presc + PW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count_out <= '0;
      reload    <= '0;
      presc     <= '0;
      mode      <= 1'b0;
      expired   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_next;
      count_out <= count_next;
      reload    <= reload_next;
      presc     <= presc_next;
      mode      <= mode_next;
      expired   <= expired_next;
      irq       <= irq_next;
    end
  end

endmodule
